uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 18 +
 rtl/rx_sync.sv | 21 ++
 rtl/uart_rx.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width and default bit timing.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int DATA_W               = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } uart_state_t;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module rx_sync (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with single-byte holding register, Valid/Ready handoff and sticky
// error flags. Define UART_RX_PARITY_EN to add an even-parity bit and Parity_err.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              Rx,
    input  logic              Ready,
    input  logic              Clear,
    output logic [DATA_W-1:0] Data_out,
    output logic              Valid,
    output logic              Overrun,
    output logic              Frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic              Parity_err
`endif
);

    localparam logic [15:0] HALF    = 16'(CLKS_PER_BIT / 2);
    localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

    uart_state_t       state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              rx_s, rx_prev;
    logic [2:0]        settle;
    logic              armed, expired;
    logic              deliver, frm_set;
`ifdef UART_RX_PARITY_EN
    logic              par_bad_q, par_bad_d, par_set;
`endif

    rx_sync u_sync (
        .clock (clock),
        .reset (reset),
        .d     (Rx),
        .q     (rx_s)
    );

    // Edge detection waits until rx_prev reflects the real line, so a line held low
    // across reset release is not mistaken for a start bit.
    assign armed   = settle[2];
    assign expired = (cnt_q == 16'd0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            rx_prev   <= 1'b1;
            settle    <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            rx_prev   <= rx_s;
            settle    <= {settle[1:0], 1'b1};
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = expired ? cnt_q : cnt_q - 16'd1;
        bit_d     = bit_q;
        shift_d   = shift_q;
        deliver   = 1'b0;
        frm_set   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        par_set   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (armed && rx_prev && !rx_s) begin
                    state_d = START;
                    cnt_d   = HALF;
                end
            end
            START: if (expired) begin
                if (!rx_s) begin
                    state_d = DATA;
                    cnt_d   = FULL_M1;
                    bit_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: if (expired) begin
                shift_d = {rx_s, shift_q[DATA_W-1:1]};
                cnt_d   = FULL_M1;
                bit_d   = bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                if (bit_q == 3'd7) state_d = PARITY;
`else
                if (bit_q == 3'd7) state_d = STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (expired) begin
                par_bad_d = rx_s != (^shift_q);
                cnt_d     = FULL_M1;
                state_d   = STOP;
            end
`endif
            STOP: if (expired) begin
                state_d = IDLE;
                cnt_d   = '0;
                if (!rx_s) frm_set = 1'b1;
`ifdef UART_RX_PARITY_EN
                else if (par_bad_q) par_set = 1'b1;
`endif
                else deliver = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Holding register: a new byte replaces the old one only if the old one is
    // consumed on that same edge; otherwise it is dropped and Overrun is raised.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            Data_out   <= '0;
            Valid      <= 1'b0;
            Overrun    <= 1'b0;
            Frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            Parity_err <= 1'b0;
`endif
        end else begin
            if (deliver && (!Valid || Ready)) begin
                Data_out <= shift_q;
                Valid    <= 1'b1;
            end else if (Valid && Ready) begin
                Valid    <= 1'b0;
            end
            Overrun    <= (Overrun & ~Clear) | (deliver & Valid & ~Ready);
            Frame_err  <= (Frame_err & ~Clear) | frm_set;
`ifdef UART_RX_PARITY_EN
            Parity_err <= (Parity_err & ~Clear) | par_set;
`endif
        end
    end

endmodule
